spi_result_transmitter: RTL and testbench
=========================================

Name: spi_result_transmitter

Overview:
Return path of the edge-detection accelerator. It packs 4-bit edge results from the pipeline into 16-bit SPI words, three nibbles per word, and buffers the words in a small FIFO. It then shifts them out to the MCU with the FPGA acting as SPI controller (mode 0, MSB first). The word layout matches the inbound pixel word, so the MCU reuses a single 16-bit unpacker.

Parameters:
CLK_DIV, 4, SCK half-period in mainClk cycles (>=2)
FIFO_DEPTH, 8, word FIFO depth (power of 2, >=2)

Ports:
mainClk  input  1  system clock; all logic on rising edge
nreset  input  1  asynchronous active-low reset
resultData  input  4  edge magnitude nibble
resultSof  input  1  qualifies resultData as pixel (0,0) of a frame
resultValid  input  1  resultData/resultSof valid this cycle
resultReady  output  1  nibble accepted when resultValid && resultReady
flush  input  1  one-cycle pulse: send the partially packed word
sck  output  1  SPI clock, idles low
sdo  output  1  SPI data to MCU
ncs  output  1  SPI chip select, active low
busy  output  1  high when FIFO non-empty, packer non-empty, flush pending, or state != IDLE

Behaviour:
- Reset values, asynchronous: ncs=1, sck=0, sdo=0, busy=0, FIFO empty, packCount=0, flushPending=0, state=IDLE. resultReady=1 from the first clock after reset release. Reset asserted mid-frame aborts the frame immediately; no partial word is resumed.
- resultReady = ~fifoFull (combinational from registered FIFO count).
- Packer: accepted nibble goes to slot packCount. Slot 0 → word[11:8], slot 1 → [7:4], slot 2 → [3:0]. The sof flag accumulates as an OR over the group.
- On the third nibble, push word = {sofAcc, 1'b0, 2'd3, slots} in that same cycle, then clear packCount and sofAcc.
- Unfilled slots read 0.
- flush sets flushPending. While flushPending && packCount!=0 && ~fifoFull, push word = {sofAcc, 0, packCount[1:0], slots}, then clear packCount, sofAcc and flushPending.
- flushPending with packCount==0 clears with no push.
- flush coincident with an accepted nibble: the nibble is packed first, and the push uses the updated count. If that count is 3, this is the normal push and flushPending clears.
- FIFO: at most one push and one pop per cycle. A push is never attempted when full (guarded by ready/flush rules). Pop occurs only on the IDLE→SETUP transition.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP. Each non-IDLE state lasts exactly CLK_DIV cycles, counted by divCnt.
- IDLE: if FIFO non-empty, pop into shiftReg, set bitCnt=0, ncs←0, sdo←word[15], go to SETUP.
- SETUP → HIGH: sck←1 (MCU samples on rising edge).
- HIGH, end of phase:
  - if bitCnt==15: sck←0 → HOLD.
  - else: sck←0, shift so sdo←next bit, bitCnt+1 → LOW.
- LOW → HIGH: sck←1.
- HOLD → GAP: ncs←1, sdo←0.
- GAP → IDLE.
- Per word: ncs low for 33*CLK_DIV cycles, with 16 rising SCK edges. Minimum ncs-high gap is CLK_DIV cycles plus 1 IDLE cycle. Back-to-back words are sent with no extra idle.
- sdo is stable for ≥CLK_DIV cycles around every rising sck edge. sdo changes only on falling sck edges or at ncs edges.

Test Plan:
- resultData 0xA (sof=1), 0x5, 0xF on consecutive cycles → one frame, ncs low 132 cycles (CLK_DIV=4), 16 rising-edge samples read 0xBA5F.
- Nibbles 0x1, 0x2, 0x3 with sof=0 → word 0x3123. Nibble 0x7 then flush pulse → word 0x1700. Flush with empty packer → no frame, busy returns to 0.
- Flush on the same cycle as the 2nd nibble (0x4, 0x9) → word 0x2490.
- Hold sck low, feed 24+ nibbles continuously → resultReady drops after 8 words are queued. No nibble is lost or duplicated; all words are sent in order with ncs gaps of ≥5 cycles.
- Assert nreset in the LOW phase of bit 7 → ncs=1, sck=0, sdo=0, busy=0 asynchronously. After release, a new nibble triple produces a clean full frame.
- CLK_DIV=2 regression of test 1 → ncs low 66 cycles, same 0xBA5F.

Source files
------------

// File: rtl/spi_result_transmitter.sv
// spi_result_transmitter: packs 4-bit edge results into 16-bit words, queues them
// and shifts them to the MCU as an SPI mode-0 controller, MSB first.
module spi_result_transmitter #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       mainClk,
  input  logic       nreset,
  input  logic [3:0] resultData,
  input  logic       resultSof,
  input  logic       resultValid,
  output logic       resultReady,
  input  logic       flush,
  output logic       sck,
  output logic       sdo,
  output logic       ncs,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
  state_t        state_q;
  logic [DW-1:0] div_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [14:0]   shift_q;
  logic          sck_q, sdo_q, ncs_q;
  logic [1:0]    pack_cnt_q, pack_cnt_d, cnt_a;
  logic [11:0]   slots_q, slots_d, slots_a;
  logic          sof_acc_q, sof_acc_d, flush_pend_q, flush_pend_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          accept, full, push, pop, full_push, sof_a, fp_a;
  logic [15:0]   push_word;
  assign full        = fifo_cnt_q == (AW+1)'(FIFO_DEPTH);
  assign resultReady = ~full;
  assign pop         = state_q == IDLE && fifo_cnt_q != '0;
  assign busy        = fifo_cnt_q != '0 || pack_cnt_q != '0 || flush_pend_q || state_q != IDLE;
  assign sck         = sck_q;
  assign sdo         = sdo_q;
  assign ncs         = ncs_q;
  // The incoming nibble is packed first so a coincident flush sees the updated group.
  always_comb begin
    accept       = resultValid & resultReady;
    cnt_a        = pack_cnt_q + 2'(accept);
    slots_a      = !accept ? slots_q :
                   pack_cnt_q == 2'd0 ? {resultData, 8'h00} :
                   pack_cnt_q == 2'd1 ? {slots_q[11:8], resultData, 4'h0} :
                   {slots_q[11:4], resultData};
    sof_a        = sof_acc_q | (accept & resultSof);
    fp_a         = flush_pend_q | flush;
    full_push    = accept && pack_cnt_q == 2'd2;
    push         = full_push || (fp_a && cnt_a != 2'd0 && !full);
    push_word    = {sof_a, 1'b0, full_push ? 2'd3 : cnt_a, slots_a};
    pack_cnt_d   = push ? 2'd0 : cnt_a;
    slots_d      = push ? 12'h000 : slots_a;
    sof_acc_d    = push ? 1'b0 : sof_a;
    flush_pend_d = (push || cnt_a == 2'd0) ? 1'b0 : fp_a;
  end
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      pack_cnt_q   <= '0;
      slots_q      <= '0;
      sof_acc_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      pack_cnt_q   <= pack_cnt_d;
      slots_q      <= slots_d;
      sof_acc_q    <= sof_acc_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_q + AW'(push);
      rd_ptr_q     <= rd_ptr_q + AW'(pop);
      fifo_cnt_q   <= fifo_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge mainClk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end
  // Bit 15 goes straight to sdo on load; shift_q holds the remaining 15 bits.
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sck_q     <= 1'b0;
      sdo_q     <= 1'b0;
      ncs_q     <= 1'b1;
    end else if (state_q == IDLE) begin
      div_cnt_q <= '0;
      if (pop) begin
        shift_q   <= mem_q[rd_ptr_q][14:0];
        sdo_q     <= mem_q[rd_ptr_q][15];
        bit_cnt_q <= '0;
        ncs_q     <= 1'b0;
        state_q   <= SETUP;
      end
    end else if (div_cnt_q != DW'(CLK_DIV - 1)) begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end else begin
      div_cnt_q <= '0;
      case (state_q)
        SETUP, LOW: begin
          sck_q   <= 1'b1;
          state_q <= HIGH;
        end
        HIGH: begin
          sck_q <= 1'b0;
          if (bit_cnt_q == 4'd15) state_q <= HOLD;
          else begin
            sdo_q     <= shift_q[14];
            shift_q   <= {shift_q[13:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= LOW;
          end
        end
        HOLD: begin
          ncs_q   <= 1'b1;
          sdo_q   <= 1'b0;
          state_q <= GAP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_result_transmitter.sv
// tb_spi_result_transmitter: scoreboard bench; instance 0 uses CLK_DIV=4, instance 1 CLK_DIV=2.
module tb_spi_result_transmitter;
  logic       clk = 1'b0;
  logic [1:0] rst_n, sof, vld, rdy, fl, sck, sdo, ncs, busy;
  logic [3:0] dat [2];
  int tests = 0, fails = 0;
  logic [15:0] exp_q [2][$];
  logic [3:0]  g_n [2][3];
  int          g_c [2];
  logic        g_s [2];
  int          m_nb [2], m_low [2], m_gap [2], frames [2];
  logic        m_seen [2], m_psck [2], m_pncs [2];
  logic [15:0] m_sh [2], last_w [2];
  logic        track = 1'b0, stalled = 1'b0;
  int          stall_depth = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gd
    spi_result_transmitter #(.CLK_DIV(g == 0 ? 4 : 2), .FIFO_DEPTH(8)) u_dut (
      .mainClk(clk), .nreset(rst_n[g]), .resultData(dat[g]), .resultSof(sof[g]),
      .resultValid(vld[g]), .resultReady(rdy[g]), .flush(fl[g]),
      .sck(sck[g]), .sdo(sdo[g]), .ncs(ncs[g]), .busy(busy[g]));
  end
  function automatic int cd(input int k);
    return k == 0 ? 4 : 2;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_group(input int k);
    g_c[k] = 0;
    g_s[k] = 1'b0;
    for (int i = 0; i < 3; i++) g_n[k][i] = 4'h0;
  endtask
  task automatic push_group(input int k);
    if (g_c[k] != 0) exp_q[k].push_back({g_s[k], 1'b0, 2'(g_c[k]), g_n[k][0], g_n[k][1], g_n[k][2]});
    clear_group(k);
  endtask
  task automatic put(input int k, input logic [3:0] d, input logic s, input logic f);
    int w = 0;
    @(negedge clk);
    dat[k] = d; sof[k] = s; vld[k] = 1'b1; fl[k] = f;
    while (!rdy[k] && w < 2000) begin
      if (track && !stalled) begin
        stalled     = 1'b1;
        stall_depth = exp_q[k].size();
      end
      @(negedge clk);
      w++;
    end
    chk("ready wait", w < 2000, 1'b1);
    g_n[k][g_c[k]] = d;
    g_c[k]++;
    g_s[k] = g_s[k] | s;
    if (g_c[k] == 3 || f) push_group(k);
    @(posedge clk);
    #1 vld[k] = 1'b0; fl[k] = 1'b0;
  endtask
  task automatic flush_only(input int k);
    @(negedge clk);
    fl[k] = 1'b1; vld[k] = 1'b0;
    push_group(k);
    @(posedge clk);
    #1 fl[k] = 1'b0;
  endtask
  task automatic wait_idle(input int k);
    int w = 0;
    do begin
      @(negedge clk);
      #1 w++;
    end while ((exp_q[k].size() != 0 || busy[k]) && w < 20000);
    chk("drain", w < 20000, 1'b1);
    chk("busy idle", busy[k], 1'b0);
  endtask
  // Frame monitor: samples SPI pins on the falling clock edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      frames[k] = 0; last_w[k] = '0; m_sh[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n[k]) begin
          m_nb[k] = 0; m_low[k] = 0; m_gap[k] = 0;
          m_seen[k] = 1'b0; m_psck[k] = 1'b0; m_pncs[k] = 1'b1;
        end else if (!ncs[k]) begin
          if (m_pncs[k]) begin
            if (m_seen[k]) chk("ncs gap", m_gap[k] >= cd(k) + 1, 1'b1);
            m_nb[k] = 0; m_low[k] = 0; m_sh[k] = '0;
          end
          m_low[k]++;
          if (sck[k] && !m_psck[k]) begin
            m_sh[k] = {m_sh[k][14:0], sdo[k]};
            m_nb[k]++;
          end
          m_psck[k] = sck[k]; m_pncs[k] = 1'b0;
        end else begin
          if (!m_pncs[k]) begin
            chk("rising edges", m_nb[k], 16);
            chk("ncs low cycles", m_low[k], 33 * cd(k));
            chk("frame expected", exp_q[k].size() > 0, 1'b1);
            if (exp_q[k].size() > 0) chk("word", m_sh[k], exp_q[k].pop_front());
            last_w[k] = m_sh[k];
            frames[k]++;
            m_seen[k] = 1'b1;
            m_gap[k] = 0;
          end
          chk("sck idle", sck[k], 1'b0);
          m_gap[k]++;
          m_psck[k] = sck[k]; m_pncs[k] = 1'b1;
        end
      end
    end
  end
  initial begin
    int f0, w;
    rst_n = 2'b00; vld = '0; fl = '0; sof = '0;
    for (int k = 0; k < 2; k++) begin
      dat[k] = 4'h0;
      clear_group(k);
    end
    #23;
    for (int k = 0; k < 2; k++) begin
      chk("reset ncs", ncs[k], 1'b1);
      chk("reset sck", sck[k], 1'b0);
      chk("reset sdo", sdo[k], 1'b0);
      chk("reset busy", busy[k], 1'b0);
    end
    @(negedge clk) rst_n = 2'b11;
    @(negedge clk);
    chk("ready after reset", rdy, 2'b11);
    put(0, 4'hA, 1'b1, 1'b0); put(0, 4'h5, 1'b0, 1'b0); put(0, 4'hF, 1'b0, 1'b0);
    wait_idle(0);
    chk("sof word", last_w[0], 16'hBA5F);
    put(0, 4'h1, 1'b0, 1'b0); put(0, 4'h2, 1'b0, 1'b0); put(0, 4'h3, 1'b0, 1'b0);
    wait_idle(0);
    chk("plain word", last_w[0], 16'h3123);
    put(0, 4'h7, 1'b0, 1'b0);
    flush_only(0);
    wait_idle(0);
    chk("flush one nibble", last_w[0], 16'h1700);
    f0 = frames[0];
    flush_only(0);
    repeat (300) @(negedge clk);
    chk("empty flush no frame", frames[0], f0);
    chk("empty flush busy", busy[0], 1'b0);
    put(0, 4'h4, 1'b0, 1'b0); put(0, 4'h9, 1'b0, 1'b1);
    wait_idle(0);
    chk("flush with nibble", last_w[0], 16'h2490);
    f0 = frames[0];
    track = 1'b1;
    for (int i = 0; i < 30; i++) put(0, 4'(i * 7 + 3), (i % 7) == 0, 1'b0);
    track = 1'b0;
    wait_idle(0);
    chk("stall seen", stalled, 1'b1);
    chk("words queued at stall", stall_depth, 9);
    chk("stream frames", frames[0] - f0, 10);
    put(0, 4'hA, 1'b1, 1'b0); put(0, 4'h5, 1'b0, 1'b0); put(0, 4'hF, 1'b0, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      #1 w++;
    end while (!(m_nb[0] == 8 && !sck[0] && !ncs[0]) && w < 5000);
    chk("reach bit 7", w < 5000, 1'b1);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("async reset ncs", ncs[0], 1'b1);
    chk("async reset sck", sck[0], 1'b0);
    chk("async reset sdo", sdo[0], 1'b0);
    chk("async reset busy", busy[0], 1'b0);
    exp_q[0].delete();
    clear_group(0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    put(0, 4'hC, 1'b0, 1'b0); put(0, 4'h3, 1'b0, 1'b0); put(0, 4'h6, 1'b0, 1'b0);
    wait_idle(0);
    chk("word after reset", last_w[0], 16'h3C36);
    put(1, 4'hA, 1'b1, 1'b0); put(1, 4'h5, 1'b0, 1'b0); put(1, 4'hF, 1'b0, 1'b0);
    wait_idle(1);
    chk("div2 word", last_w[1], 16'hBA5F);
    chk("div2 frames", frames[1], 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
